// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared PHY types: tx scheduler states, source ids and tuser source tags
package pcie_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT_OS,
        ST_GRANT_DLLP,
        ST_GRANT_TLP,
        ST_FLUSH
    } phy_tx_sched_state_e;

    // Which requester a flush is draining
    typedef enum logic [1:0] {
        SRC_OS,
        SRC_DLLP,
        SRC_TLP
    } phy_tx_src_e;

    // Source tags on tuser; DLLP/TLP match the receive path encoding
    localparam logic [3:0] TUSER_OS   = 4'b0100;
    localparam logic [3:0] TUSER_DLLP = 4'b0001;
    localparam logic [3:0] TUSER_TLP  = 4'b0010;

endpackage

// File: rtl/phy_tx_skp_timer.sv
// rtl/phy_tx_skp_timer.sv - SKP interval counter and pending flag (used only with PHY_TX_SKP_SCHED_EN)
module phy_tx_skp_timer
    import pcie_phy_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic link_up_i,
    input  logic done_i,
    output logic pending_o
);

    localparam logic [15:0] CNT_MAX = 16'(SKP_INTERVAL - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;

    // Count up while link is up, flag pending at saturation, restart on SKP completion
    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (!link_up_i) begin
            cnt_d     = '0;
            pending_d = 1'b0;
        end else if (done_i && pending_q) begin
            cnt_d     = '0;
            pending_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            pending_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/phy_tx_scheduler.sv
// rtl/phy_tx_scheduler.sv - packet-level OS/DLLP/TLP transmit arbiter with SKP scheduling (PHY_TX_SKP_SCHED_EN)
module phy_tx_scheduler
    import pcie_phy_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int USER_WIDTH     = 4,
    parameter int SKP_INTERVAL   = 1180,
    parameter int DLLP_BURST_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  phy_link_up_i,
    input  logic [DATA_WIDTH-1:0] s_os_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_os_axis_tkeep,
    input  logic                  s_os_axis_tvalid,
    input  logic                  s_os_axis_tlast,
    output logic                  s_os_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_dllp_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_dllp_axis_tkeep,
    input  logic                  s_dllp_axis_tvalid,
    input  logic                  s_dllp_axis_tlast,
    output logic                  s_dllp_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_tlp_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tlp_axis_tkeep,
    input  logic                  s_tlp_axis_tvalid,
    input  logic                  s_tlp_axis_tlast,
    output logic                  s_tlp_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  skp_req_o
);

    localparam int BURST_W = $clog2(DLLP_BURST_MAX + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(DLLP_BURST_MAX);

    phy_tx_sched_state_e state_q, state_d;
    phy_tx_src_e         flush_src_q, flush_src_d;
    logic [BURST_W-1:0]  dllp_burst_q, dllp_burst_d;
    logic                os_done;
    logic                skp_pending;

`ifdef PHY_TX_SKP_SCHED_EN
    phy_tx_skp_timer #(
        .SKP_INTERVAL(SKP_INTERVAL)
    ) u_skp_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .link_up_i (phy_link_up_i),
        .done_i    (os_done),
        .pending_o (skp_pending)
    );
    assign skp_req_o = skp_pending;
`else
    logic skp_unused;
    assign skp_pending = 1'b0;
    assign skp_req_o   = 1'b0;
    assign skp_unused  = os_done ^ (SKP_INTERVAL == 0);
`endif

    // Arbitration, output mux, ready steering and flush sequencing
    always_comb begin
        state_d            = state_q;
        flush_src_d        = flush_src_q;
        dllp_burst_d       = dllp_burst_q;
        os_done            = 1'b0;
        m_axis_tdata       = '0;
        m_axis_tkeep       = '0;
        m_axis_tvalid      = 1'b0;
        m_axis_tlast       = 1'b0;
        m_axis_tuser       = '0;
        s_os_axis_tready   = 1'b0;
        s_dllp_axis_tready = 1'b0;
        s_tlp_axis_tready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (phy_link_up_i) begin
                    if (s_os_axis_tvalid) begin
                        state_d = ST_GRANT_OS;
                    end else if (!skp_pending) begin
                        if (s_tlp_axis_tvalid && dllp_burst_q == BURST_MAX) begin
                            state_d = ST_GRANT_TLP;
                        end else if (s_dllp_axis_tvalid) begin
                            state_d = ST_GRANT_DLLP;
                            if (!s_tlp_axis_tvalid) dllp_burst_d = '0;
                        end else if (s_tlp_axis_tvalid) begin
                            state_d = ST_GRANT_TLP;
                        end
                    end
                end
            end
            ST_GRANT_OS: begin
                m_axis_tdata     = s_os_axis_tdata;
                m_axis_tkeep     = s_os_axis_tkeep;
                m_axis_tvalid    = s_os_axis_tvalid;
                m_axis_tlast     = s_os_axis_tlast;
                m_axis_tuser     = s_os_axis_tvalid ? USER_WIDTH'(TUSER_OS) : '0;
                s_os_axis_tready = m_axis_tready;
                if (s_os_axis_tvalid && m_axis_tready && s_os_axis_tlast) begin
                    os_done = 1'b1;
                    state_d = ST_IDLE;
                end else if (!phy_link_up_i) begin
                    state_d     = ST_FLUSH;
                    flush_src_d = SRC_OS;
                end
            end
            ST_GRANT_DLLP: begin
                m_axis_tdata       = s_dllp_axis_tdata;
                m_axis_tkeep       = s_dllp_axis_tkeep;
                m_axis_tvalid      = s_dllp_axis_tvalid;
                m_axis_tlast       = s_dllp_axis_tlast;
                m_axis_tuser       = s_dllp_axis_tvalid ? USER_WIDTH'(TUSER_DLLP) : '0;
                s_dllp_axis_tready = m_axis_tready;
                if (s_dllp_axis_tvalid && m_axis_tready && s_dllp_axis_tlast) begin
                    state_d = ST_IDLE;
                    if (s_tlp_axis_tvalid && dllp_burst_q != BURST_MAX) begin
                        dllp_burst_d = dllp_burst_q + BURST_W'(1);
                    end
                end else if (!phy_link_up_i) begin
                    state_d     = ST_FLUSH;
                    flush_src_d = SRC_DLLP;
                end
            end
            ST_GRANT_TLP: begin
                m_axis_tdata      = s_tlp_axis_tdata;
                m_axis_tkeep      = s_tlp_axis_tkeep;
                m_axis_tvalid     = s_tlp_axis_tvalid;
                m_axis_tlast      = s_tlp_axis_tlast;
                m_axis_tuser      = s_tlp_axis_tvalid ? USER_WIDTH'(TUSER_TLP) : '0;
                s_tlp_axis_tready = m_axis_tready;
                if (s_tlp_axis_tvalid && m_axis_tready && s_tlp_axis_tlast) begin
                    state_d      = ST_IDLE;
                    dllp_burst_d = '0;
                end else if (!phy_link_up_i) begin
                    state_d     = ST_FLUSH;
                    flush_src_d = SRC_TLP;
                end
            end
            ST_FLUSH: begin
                case (flush_src_q)
                    SRC_OS: begin
                        s_os_axis_tready = 1'b1;
                        if (s_os_axis_tvalid && s_os_axis_tlast) state_d = ST_IDLE;
                    end
                    SRC_DLLP: begin
                        s_dllp_axis_tready = 1'b1;
                        if (s_dllp_axis_tvalid && s_dllp_axis_tlast) state_d = ST_IDLE;
                    end
                    SRC_TLP: begin
                        s_tlp_axis_tready = 1'b1;
                        if (s_tlp_axis_tvalid && s_tlp_axis_tlast) state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            flush_src_q  <= SRC_OS;
            dllp_burst_q <= '0;
        end else begin
            state_q      <= state_d;
            flush_src_q  <= flush_src_d;
            dllp_burst_q <= dllp_burst_d;
        end
    end

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// tb/tb_phy_tx_scheduler.sv - scoreboard bench for phy_tx_scheduler
module tb_phy_tx_scheduler;
    import pcie_phy_pkg::*;

    localparam int DW   = 32;
    localparam int KW   = 4;
    localparam int UW   = 4;
    localparam int SKP  = 40;
    localparam int BMAX = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic link;
    logic m_ready;

    logic [DW-1:0] sd [3];
    logic [KW-1:0] sk [3];
    logic          sv [3];
    logic          sl [3];
    logic          os_rdy, dllp_rdy, tlp_rdy;

    logic [DW-1:0] m_data;
    logic [KW-1:0] m_keep;
    logic          m_valid, m_last;
    logic [UW-1:0] m_user;
    logic          skp_req;

    beat_t src_q [3][$];
    exp_t  exp_q [$];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    phy_tx_scheduler #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
        .SKP_INTERVAL(SKP), .DLLP_BURST_MAX(BMAX)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .phy_link_up_i      (link),
        .s_os_axis_tdata    (sd[0]),
        .s_os_axis_tkeep    (sk[0]),
        .s_os_axis_tvalid   (sv[0]),
        .s_os_axis_tlast    (sl[0]),
        .s_os_axis_tready   (os_rdy),
        .s_dllp_axis_tdata  (sd[1]),
        .s_dllp_axis_tkeep  (sk[1]),
        .s_dllp_axis_tvalid (sv[1]),
        .s_dllp_axis_tlast  (sl[1]),
        .s_dllp_axis_tready (dllp_rdy),
        .s_tlp_axis_tdata   (sd[2]),
        .s_tlp_axis_tkeep   (sk[2]),
        .s_tlp_axis_tvalid  (sv[2]),
        .s_tlp_axis_tlast   (sl[2]),
        .s_tlp_axis_tready  (tlp_rdy),
        .m_axis_tdata       (m_data),
        .m_axis_tkeep       (m_keep),
        .m_axis_tvalid      (m_valid),
        .m_axis_tlast       (m_last),
        .m_axis_tuser       (m_user),
        .m_axis_tready      (m_ready),
        .skp_req_o          (skp_req)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    function automatic logic src_rdy(input int s);
        case (s)
            0:       return os_rdy;
            1:       return dllp_rdy;
            default: return tlp_rdy;
        endcase
    endfunction

    function automatic logic [DW-1:0] beat_data(input int s, input int id, input int b);
        return {8'(s + 1), 8'(id), 16'(b)};
    endfunction

    function automatic logic [KW-1:0] src_keep(input int s);
        return (s == 1) ? 4'h3 : 4'hF;
    endfunction

    function automatic logic [UW-1:0] src_user(input int s);
        case (s)
            0:       return TUSER_OS;
            1:       return TUSER_DLLP;
            default: return TUSER_TLP;
        endcase
    endfunction

    task automatic push_src(input int s, input int id, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = beat_data(s, id, i);
            b.keep = src_keep(s);
            b.last = (i == n - 1);
            src_q[s].push_back(b);
        end
    endtask

    // Expect the first cnt beats of an n-beat packet on the output
    task automatic push_exp(input int s, input int id, input int n, input int cnt);
        exp_t e;
        for (int i = 0; i < cnt; i++) begin
            e.data = beat_data(s, id, i);
            e.keep = src_keep(s);
            e.user = src_user(s);
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // Source model: present the queue head, pop it after an observed handshake
    task automatic drive_src(input int s);
        logic hs;
        forever begin
            @(negedge clk);
            hs = sv[s] && src_rdy(s);
            @(posedge clk);
            #1;
            if (hs && src_q[s].size() > 0) void'(src_q[s].pop_front());
            if (src_q[s].size() > 0) begin
                sv[s] = 1'b1;
                sd[s] = src_q[s][0].data;
                sk[s] = src_q[s][0].keep;
                sl[s] = src_q[s][0].last;
            end else begin
                sv[s] = 1'b0;
                sd[s] = '0;
                sk[s] = '0;
                sl[s] = 1'b0;
            end
        end
    endtask

    // Scoreboard monitor: every output handshake is compared with the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", m_data, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {m_data, m_keep, m_user, m_last}, {e.data, e.keep, e.user, e.last});
                end
            end
        end
    end

    task automatic wait_drain(input string name, input int budget);
        int i;
        i = 0;
        while (i < budget && (exp_q.size() != 0 || src_q[0].size() != 0 ||
                              src_q[1].size() != 0 || src_q[2].size() != 0)) begin
            @(negedge clk);
            i++;
        end
        check(name, 64'(exp_q.size() + src_q[0].size() + src_q[1].size() + src_q[2].size()), 0);
    endtask

    task automatic link_bounce();
        @(posedge clk); #1;
        link = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        link = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int i;
        rst = 1'b1;
        link = 1'b0;
        m_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sv[s] = 1'b0; sd[s] = '0; sk[s] = '0; sl[s] = 1'b0;
        end
        fork
            drive_src(0);
            drive_src(1);
            drive_src(2);
        join_none
        repeat (3) @(negedge clk);
        check("reset_m_outputs", {m_valid, m_last, m_user, m_data, m_keep}, '0);
        check("reset_readies", {os_rdy, dllp_rdy, tlp_rdy}, 3'b000);
        check("reset_skp_req", skp_req, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        link = 1'b1;

        // DLLP and TLP together: DLLP at N+1, bubble, then TLP
        @(negedge clk);
        push_src(1, 1, 1);
        push_src(2, 1, 2);
        push_exp(1, 1, 1, 1);
        push_exp(2, 1, 2, 2);
        @(negedge clk);
        check("grant_cycle_n_idle", m_valid, 0);
        @(negedge clk);
        check("dllp_grant_n1", {m_valid, m_user}, {1'b1, TUSER_DLLP});
        @(negedge clk);
        check("bubble_after_dllp", {m_valid, m_user}, 5'b0);
        @(negedge clk);
        check("tlp_after_bubble", {m_valid, m_user}, {1'b1, TUSER_TLP});
        wait_drain("drain_dllp_tlp", 40);

        // OS wins over DLLP
        link_bounce();
        @(negedge clk);
        push_src(0, 2, 2);
        push_src(1, 2, 1);
        push_exp(0, 2, 2, 2);
        push_exp(1, 2, 1, 1);
        wait_drain("drain_os_prio", 40);

        // DLLP burst limit with a waiting TLP: D,D,D,D,T,D,D
        link_bounce();
        @(negedge clk);
        for (int k = 0; k < 6; k++) push_src(1, 10 + k, 1);
        push_src(2, 20, 2);
        for (int k = 0; k < 4; k++) push_exp(1, 10 + k, 1, 1);
        push_exp(2, 20, 2, 2);
        push_exp(1, 14, 1, 1);
        push_exp(1, 15, 1, 1);
        wait_drain("drain_burst", 60);

        // Backpressure for 5 cycles mid-packet
        link_bounce();
        @(negedge clk);
        push_src(2, 30, 4);
        push_exp(2, 30, 4, 4);
        i = 0;
        while (!m_valid && i < 10) begin
            @(negedge clk);
            i++;
        end
        check("bp_first_beat", m_data, beat_data(2, 30, 0));
        @(posedge clk); #1;
        m_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold", {m_valid, m_user, m_data, tlp_rdy},
                  {1'b1, TUSER_TLP, beat_data(2, 30, 1), 1'b0});
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_drain("drain_bp", 40);

        // Link drop during the 3rd beat of an 8-beat TLP
        link_bounce();
        @(negedge clk);
        push_src(2, 40, 8);
        push_exp(2, 40, 8, 3);
        i = 0;
        while (!(m_valid && m_data == beat_data(2, 40, 1)) && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("ld_beat2_seen", m_data, beat_data(2, 40, 1));
        @(posedge clk); #1;
        link = 1'b0;
        @(negedge clk);
        check("ld_beat3_out", {m_valid, m_data}, {1'b1, beat_data(2, 40, 2)});
        @(negedge clk);
        check("ld_flush_state", {m_valid, tlp_rdy}, 2'b01);
        i = 0;
        while (src_q[2].size() != 0 && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("ld_flush_drained", src_q[2].size(), 0);
        check("ld_back_idle", {m_valid, tlp_rdy, os_rdy, dllp_rdy}, 4'b0);
        check("ld_exp_done", exp_q.size(), 0);
        @(posedge clk); #1;
        link = 1'b1;
        repeat (3) @(negedge clk);
`ifndef PHY_TX_SKP_SCHED_EN
        check("skp_req_tied_low", skp_req, 0);
`endif

`ifdef PHY_TX_SKP_SCHED_EN
        // SKP expiry during a long TLP; DLLP held off until the OS completes
        link_bounce();
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (c == 20) begin
                push_src(2, 50, 30);
                push_exp(2, 50, 30, 30);
            end
            if (c == 39) check("skp_req_before", skp_req, 0);
            if (c == 40) check("skp_req_rise", skp_req, 1);
        end
        push_src(1, 51, 1);
        push_exp(0, 52, 2, 2);
        push_exp(1, 51, 1, 1);
        i = 0;
        while (exp_q.size() != 3 && i < 60) begin
            @(negedge clk);
            i++;
        end
        check("skp_tlp_intact", exp_q.size(), 3);
        repeat (4) begin
            @(negedge clk);
            check("skp_hold_dllp", {m_valid, skp_req}, 2'b01);
        end
        push_src(0, 52, 2);
        wait_drain("drain_skp", 40);
        check("skp_req_drop", skp_req, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/phy_tx_scheduler.md
# phy_tx_scheduler

Packet-level transmit scheduler that shares the PHY transmit datapath between three AXIS requesters: ordered sets, DLLPs and TLPs. Its single AXIS output feeds the transmit framing and lane-striping stage. It grants whole packets in priority order and forces periodic SKP ordered-set insertion at packet boundaries. While the link is down it drains and discards traffic.

## Interface
Parameters:
- DATA_WIDTH, 32: AXIS data width in bits.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width.
- USER_WIDTH, 4: tuser width; carries the source tag on the output.
- SKP_INTERVAL, 1180: clock cycles between SKP requests; range 2..65535.
- DLLP_BURST_MAX, 4: consecutive DLLP grants allowed while a TLP waits.

Ports (clock and reset first):
- clk_i, in, 1: single clock.
- rst_i, in, 1: synchronous, active-high reset.
- phy_link_up_i, in, 1: link up.
- s_os_axis_tdata / tkeep / tvalid / tlast / tready, in/in/in/in/out, DATA_WIDTH / KEEP_WIDTH / 1 / 1 / 1: ordered-set source.
- s_dllp_axis_*, same set and widths: DLLP source.
- s_tlp_axis_*, same set and widths: TLP source.
- m_axis_tdata / tkeep / tvalid / tlast / tuser / tready, out/out/out/out/out/in, DATA_WIDTH / KEEP_WIDTH / 1 / 1 / USER_WIDTH / 1: to the framing stage.
- skp_req_o, out, 1: SKP request to the ordered-set generator.

## Operation
- States are ST_IDLE, ST_GRANT_OS, ST_GRANT_DLLP, ST_GRANT_TLP and ST_FLUSH.
- ST_IDLE arbitration, with phy_link_up_i=1. The first matching rule wins:
  - skp_pending and s_os tvalid: grant OS.
  - s_os tvalid: grant OS.
  - TLP tvalid and dllp_burst==DLLP_BURST_MAX: grant TLP.
  - DLLP tvalid: grant DLLP.
  - TLP tvalid: grant TLP.
- While skp_pending=1, ST_IDLE does not grant DLLP or TLP. skp_req_o is held at 1 until the OS packet completes.
- In a grant state:
  - m_axis_tdata, tkeep, tvalid and tlast are a combinational mux of the granted source.
  - The granted source's tready equals m_axis_tready.
  - Ungranted sources see tready=0.
- m_axis_tuser (only valid while m_axis_tvalid=1, otherwise 0) tags the source: OS=4'b0100, DLLP=4'b0001, TLP=4'b0010.
- A handshake with tlast=1 returns the block to ST_IDLE.
- dllp_burst counter:
  - Increments, saturating, on each DLLP packet completion while TLP tvalid=1.
  - Clears on TLP packet completion.
  - Clears when TLP tvalid=0 at a DLLP grant.
- skp_cnt counter:
  - Increments every cycle while the link is up and saturates at SKP_INTERVAL-1.
  - At saturation, skp_pending is set.
  - An OS packet completion while skp_pending=1 clears skp_pending and resets skp_cnt to 0.
- Link down while in a grant state:
  - Next state is ST_FLUSH; m_axis_tvalid=0.
  - The granted source gets tready=1 and its beats are discarded up to and including tlast, then the block returns to ST_IDLE.
  - In ST_IDLE with the link down, nothing is granted and skp_cnt and skp_pending are held at 0.
- Reset mid-packet returns the block to ST_IDLE. The rest of the interrupted packet is not flushed; the upstream source must also be reset.

## Timing
- Reset values:
  - State ST_IDLE; skp_cnt, skp_pending and dllp_burst are 0.
  - Outputs: all s_*_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, m_axis_tkeep=0, skp_req_o=0.
- Grant latency: the arbitration decision is registered. A request seen in ST_IDLE at cycle N is granted at N+1; the first output beat can transfer at N+1.
- Each packet is followed by exactly one ST_IDLE bubble cycle.
- Datapath latency is zero cycles (combinational mux). The downstream register stage supplies the pipelining.
- tvalid must not depend on tready. A granted source that deasserts tvalid mid-packet keeps the grant.
- skp_req_o is registered and rises the cycle after skp_cnt saturates.
- A DLLP or TLP packet in flight when the SKP interval expires is never cut. SKP waits for tlast.

## Configuration
- PHY_TX_SKP_SCHED_EN defined: the SKP interval counter, skp_pending and skp_req_o behave as described above.
- Not defined: there is no counter. skp_req_o is tied to 0 and the OS source is arbitrated only by its tvalid. The SKP_INTERVAL parameter is ignored.

## Structure
- pcie_phy_pkg gains:
  - The phy_tx_sched_state_e enum.
  - Source-tag constants TUSER_OS, TUSER_DLLP and TUSER_TLP, shared with the receive path's 4'b0001/4'b0010 encoding.
- One natural sub-module, phy_tx_skp_timer: the interval counter and pending flag, with ports clk_i, rst_i, link_up_i, done_i, pending_o.

## Test plan
- DLLP and TLP both valid in the same cycle, link up → DLLP granted at N+1 with tuser=4'b0001; TLP follows after one bubble cycle with tuser=4'b0010.
- Continuous DLLP stream with TLP waiting, DLLP_BURST_MAX=4 → grant order is D,D,D,D,T,D.
- SKP_INTERVAL=16, long TLP in flight at expiry → skp_req_o=1 at cycle 16; TLP completes intact; OS granted next; skp_req_o drops after the OS tlast.
- With skp_pending=1 and DLLP valid but OS not yet valid → no DLLP grant until OS completes.
- phy_link_up_i drops in the 3rd beat of an 8-beat TLP → m_axis_tvalid=0 the next cycle; TLP beats 4–8 accepted and discarded; state returns to ST_IDLE.
- m_axis_tready held low for 5 cycles mid-packet → output data stable, granted tready=0, grant retained.
